gf_rca_div: RTL and testbench
=============================

# gf_rca_div

Sequential bit-serial divider that is the inverse of the GF / RCA multiplier pair: it takes a 2·DATA_WIDTH-bit dividend and a DATA_WIDTH-bit divisor, and returns quotient and remainder. With `gf_option`=1 it performs carry-less GF(2)[x] reduction by the monic modulus x^DATA_WIDTH + divisor, which is field reduction of a carry-less product. With `gf_option`=0 it performs unsigned restoring integer division. It sits downstream of the multipliers and uses a valid/ready handshake on both sides.

## Interface
- `DATA_WIDTH`, default 32: operand width W; dividend and quotient are 2W bits.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block idle and able to accept a request.
- `gf_option` input 1: 1 = GF(2) polynomial mode, 0 = integer mode. Sampled at accept.
- `dividend` input 2W: sampled at accept.
- `divisor` input W: sampled at accept. In GF mode the x^W term is implicit.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed.
- `quotient` output 2W: quotient.
- `remainder` output W: remainder.
- `div_by_zero` output 1: integer mode with divisor == 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on `in_valid` & `in_ready`.
  - BUSY → DONE after 2W iterations.
  - DONE → IDLE on `out_valid` & `out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). There is no overlap: a new request is accepted only in IDLE.
- On accept, the following are captured:
  - dividend into a shift register.
  - divisor, `gf_option`.
  - partial remainder r cleared to 0.
  - iteration counter cleared.
- Each BUSY cycle takes the next dividend bit b, MSB first, and appends one quotient bit, MSB first:
  - GF mode: t = r[W-1]; r ← {r[W-2:0], b} ^ (t ? divisor : 0); quotient bit = t.
  - Integer mode: e = {r, b} (W+1 bits). If e ≥ {0, divisor}, then r ← (e − divisor)[W-1:0] and quotient bit = 1. Otherwise r ← e[W-1:0] and quotient bit = 0.
- Divisor 0, integer mode:
  - The algorithm naturally yields quotient = all ones and remainder = dividend[W-1:0]; no special datapath is needed.
  - `div_by_zero` = 1 in DONE.
- Divisor 0, GF mode: legal, with modulus x^W. Quotient = dividend >> W, remainder = dividend[W-1:0], `div_by_zero` = 0.
- In GF mode the top W quotient bits are always 0, because the first W iterations cannot set t.
- Results are registered and held stable throughout DONE, whatever `out_ready` does.
- Inputs are ignored outside the accept cycle. Input changes during BUSY or DONE have no effect.

## Timing
- Reset (async assert, synchronous-to-clk deassert handled externally):
  - State → IDLE.
  - `out_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - `in_ready`=1 while idle in reset state.
- Latency: accept on edge E0. Iterations occur on edges E1..E2W. `out_valid` rises after E2W, so results are visible 2W cycles after the accept edge.
- Throughput: one operation per 2W+2 cycles at best: accept, 2W BUSY cycles, one DONE cycle with `out_ready`=1, then IDLE.
- With `out_ready` held low, DONE persists indefinitely with outputs stable and `in_ready`=0.
- The DONE → IDLE edge does not accept a request in the same cycle. `in_ready` rises in the following cycle.
- Reset mid-BUSY or mid-DONE aborts immediately. The result is discarded and all outputs take their reset values.
- `in_valid` asserted during reset is not accepted.

## Test plan
- GF, W=8: `dividend`=16'h2B79, `divisor`=8'h1B, `gf_option`=1 → after 16 cycles, `quotient`=16'h0028, `remainder`=8'hC1, `div_by_zero`=0.
- Integer, W=8:
  - `dividend`=16'd1000, `divisor`=8'd7 → `quotient`=16'h008E, `remainder`=8'h06.
  - `dividend`=16'hFFFF, `divisor`=8'h01 → `quotient`=16'hFFFF, `remainder`=8'h00.
- Divisor 0, W=8, `dividend`=16'h1234:
  - Integer → `quotient`=16'hFFFF, `remainder`=8'h34, `div_by_zero`=1.
  - GF → `quotient`=16'h0012, `remainder`=8'h34, `div_by_zero`=0.
- Back-pressure:
  - Hold `out_ready`=0 for 10 cycles after `out_valid` → outputs stable and `in_ready`=0 throughout. A second `in_valid` is not accepted.
  - Release `out_ready` → `out_valid` drops next edge and `in_ready`=1 one cycle later.
- Reset mid-operation: assert `rst_n`=0 at iteration 5 → `out_valid`=0, all outputs 0 immediately, `in_ready`=1 after release.
  - A new request then completes with correct results in exactly 2W cycles.
- Input churn: change `dividend`, `divisor` and `gf_option` every cycle during BUSY → result matches the values sampled at accept.

Source files
------------

// File: rtl/gf_rca_div_if.sv
// Request/response bundle for gf_rca_div: valid/ready request carrying operands,
// valid/ready response carrying quotient, remainder and the divide-by-zero flag.
interface gf_rca_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    gf_option;
  logic [2*DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0]   divisor;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0]   remainder;
  logic                    div_by_zero;

  modport master (
    output in_valid, gf_option, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, gf_option, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/gf_rca_div.sv
// Bit-serial divider: carry-less GF(2)[x] reduction by x^W + divisor, or unsigned
// restoring integer division; one dividend bit consumed per cycle, MSB first.
module gf_rca_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  gf_rca_div_if.slave      bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(2 * W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]       divisor_q, divisor_d;
  logic               gf_q, gf_d;
  logic [W-1:0]       rem_q, rem_d;
  logic [2*W-1:0]     quot_q, quot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               dvd_bit;
  logic [W-1:0]       gf_rem;
  logic [W:0]         int_ext;
  logic [W:0]         int_diff;
  logic               int_ge;

  assign dvd_bit  = shreg_q[2*W-1];
  // The x^W term is implicit: when the bit shifted out is set, subtract (xor) the low part.
  assign gf_rem   = {rem_q[W-2:0], dvd_bit} ^ (rem_q[W-1] ? divisor_q : '0);
  assign int_ext  = {rem_q, dvd_bit};
  assign int_ge   = (int_ext >= {1'b0, divisor_q});
  assign int_diff = int_ext - {1'b0, divisor_q};

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    divisor_d = divisor_q;
    gf_d      = gf_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d   = BUSY;
          shreg_d   = bus.dividend;
          divisor_d = bus.divisor;
          gf_d      = bus.gf_option;
          rem_d     = '0;
          quot_d    = '0;
          cnt_d     = '0;
        end
      end
      BUSY: begin
        shreg_d = {shreg_q[2*W-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (gf_q) begin
          rem_d  = gf_rem;
          quot_d = {quot_q[2*W-2:0], rem_q[W-1]};
        end else if (int_ge) begin
          rem_d  = int_diff[W-1:0];
          quot_d = {quot_q[2*W-2:0], 1'b1};
        end else begin
          rem_d  = int_ext[W-1:0];
          quot_d = {quot_q[2*W-2:0], 1'b0};
        end
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      divisor_q <= '0;
      gf_q      <= 1'b0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      divisor_q <= divisor_d;
      gf_q      <= gf_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = (state_q == DONE) && !gf_q && (divisor_q == '0);
endmodule

// File: tb/tb_gf_rca_div.sv
// Self-checking bench for gf_rca_div at W=8: spec vectors, random operands against a
// long-division reference model, back-pressure, mid-operation reset and input churn.
module tb_gf_rca_div;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gf_rca_div_if #(.DATA_WIDTH(W)) bus ();

  gf_rca_div #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        gf;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_dbz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: schoolbook polynomial long division, or plain integer / and %.
  function automatic void model(input logic gf, input logic [15:0] dvd, input logic [7:0] dvs,
                                output logic [15:0] q, output logic [7:0] r, output logic dbz);
    logic [23:0] rem;
    logic [23:0] modp;
    q   = '0;
    dbz = 1'b0;
    if (gf) begin
      rem  = {8'h00, dvd};
      modp = {15'd0, 1'b1, dvs};
      for (int i = 15; i >= W; i--) begin
        if (rem[i]) begin
          rem = rem ^ (modp << (i - W));
          q[i-W] = 1'b1;
        end
      end
      r = rem[7:0];
    end else if (dvs == 8'd0) begin
      q   = 16'hFFFF;
      r   = dvd[7:0];
      dbz = 1'b1;
    end else begin
      q = dvd / {8'd0, dvs};
      r = 8'(dvd % {8'd0, dvs});
    end
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one request, wait for the result (checking latency), check it, then drain it.
  task automatic run_op(input string tag, input logic gf, input logic [15:0] dvd,
                        input logic [7:0] dvs, input bit churn,
                        input logic [15:0] eq, input logic [7:0] er, input logic edbz);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.gf_option = gf;
    bus.dividend  = dvd;
    bus.divisor   = dvs;
    tick();
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 100) begin
      if (churn) begin
        bus.gf_option = 1'($urandom);
        bus.dividend  = 16'($urandom);
        bus.divisor   = 8'($urandom);
        bus.in_valid  = 1'($urandom);
      end
      tick();
      w++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(w), 32'(2 * W));
    chk({tag, "_quot"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_rem"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
    $display("op %s gf=%0b dvd=%h dvs=%h -> q=%h r=%h dbz=%0b", tag, gf, dvd, dvs,
             bus.quotient, bus.remainder, bus.div_by_zero);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vec_t        vecs[5];
    logic [15:0] mq, hq;
    logic [7:0]  mr, hr, rs;
    logic        md, rg;
    logic [15:0] rd;
    bit          ok;

    vecs[0] = '{1'b1, 16'h2B79, 8'h1B, 16'h0028, 8'hC1, 1'b0};
    vecs[1] = '{1'b0, 16'd1000, 8'd7,  16'h008E, 8'h06, 1'b0};
    vecs[2] = '{1'b0, 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1};
    vecs[4] = '{1'b1, 16'h1234, 8'h00, 16'h0012, 8'h34, 1'b0};

    idle_inputs();
    bus.gf_option = 1'b0;
    bus.dividend  = 16'h0;
    bus.divisor   = 8'h0;

    // Reset state, with a request pending that must not be taken.
    bus.in_valid = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_quot", 32'(bus.quotient), 32'd0);
    chk("rst_rem", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].gf, vecs[i].dvd, vecs[i].dvs, 1'b0,
             vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dbz);
    end

    for (int i = 0; i < 40; i++) begin
      rg = 1'($urandom);
      rd = 16'($urandom);
      rs = (i % 8 == 3) ? 8'h00 : 8'($urandom);
      model(rg, rd, rs, mq, mr, md);
      run_op($sformatf("rnd%0d", i), rg, rd, rs, 1'b0, mq, mr, md);
    end

    // Input churn during BUSY must not disturb the sampled operands.
    for (int i = 0; i < 4; i++) begin
      rg = 1'(i);
      rd = 16'($urandom);
      rs = 8'($urandom);
      model(rg, rd, rs, mq, mr, md);
      run_op($sformatf("churn%0d", i), rg, rd, rs, 1'b1, mq, mr, md);
    end

    // Back-pressure: hold the result for 10 cycles while another request waits.
    bus.in_valid  = 1'b1;
    bus.gf_option = 1'b0;
    bus.dividend  = 16'd5000;
    bus.divisor   = 8'd13;
    tick();
    bus.in_valid = 1'b0;
    repeat (2 * W) tick();
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    hq = bus.quotient;
    hr = bus.remainder;
    chk("bp_quot", 32'(hq), 32'd384);
    chk("bp_rem", 32'(hr), 32'd8);
    $display("op bp dvd=%h dvs=%h -> q=%h r=%h", 16'd5000, 8'd13, hq, hr);
    bus.in_valid = 1'b1;
    bus.dividend = 16'h0BAD;
    bus.divisor  = 8'h03;
    for (int i = 0; i < 10; i++) begin
      tick();
      ok = bus.out_valid && !bus.in_ready && bus.quotient == hq && bus.remainder == hr;
      chk($sformatf("bp_hold%0d", i), 32'(ok), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_not_accepted", 32'(bus.in_ready), 32'd1);

    // Reset at iteration 5 aborts; a fresh request then completes normally.
    bus.in_valid  = 1'b1;
    bus.gf_option = 1'b1;
    bus.dividend  = 16'hFEED;
    bus.divisor   = 8'h1D;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_outs", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    model(1'b1, 16'hFEED, 8'h1D, mq, mr, md);
    run_op("after_rst", 1'b1, 16'hFEED, 8'h1D, 1'b0, mq, mr, md);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
